// File: rtl/crc_frame_tx.sv
// crc_frame_tx: collects a fixed-length payload alongside the CRC block, waits
// for its result, then sends SOF + payload + CRC as UART 8N1 bytes on tx.
module crc_frame_tx #(
  parameter int unsigned PAYLOAD_LEN  = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter logic [7:0]  SOF          = 8'h7E
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [7:0] data_in,
  input  logic       crc_done,
  input  logic [7:0] crc,
  output logic       tx,
  output logic       busy,
  output logic       frame_done,
  output logic       overflow
);

  localparam int unsigned CNT_W     = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
  localparam int unsigned TMR_W     = $clog2(CLKS_PER_BIT);
  localparam int unsigned BYTE_W    = $clog2(PAYLOAD_LEN + 2);
  localparam int unsigned BIT_W     = 4;
  localparam int unsigned LAST_BYTE = PAYLOAD_LEN + 1;
  localparam int unsigned STOP_BIT  = 9;
  localparam int unsigned LAST_DATA = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    WAIT_CRC = 2'd2,
    SEND     = 2'd3
  } state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [7:0]        crc_q, crc_q_d;
  logic [TMR_W-1:0]  bit_tmr, bit_tmr_d;
  logic [BIT_W-1:0]  bit_idx, bit_idx_d;
  logic [BYTE_W-1:0] byte_idx, byte_idx_d;
  logic              tx_d, busy_d, frame_done_d, overflow_d;
  logic              cap_en;
  logic [CNT_W-1:0]  pay_idx;
  logic [7:0]        cur_byte;
  logic [7:0]        pay_buf [PAYLOAD_LEN];

  // Byte currently on the line: SOF, then payload slot byte_idx-1, then CRC.
  always_comb begin
    pay_idx = CNT_W'(byte_idx - BYTE_W'(1));
    if (byte_idx == '0) begin
      cur_byte = SOF;
    end else if (byte_idx == BYTE_W'(LAST_BYTE)) begin
      cur_byte = crc_q;
    end else begin
      cur_byte = pay_buf[pay_idx];
    end
  end

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    crc_q_d      = crc_q;
    bit_tmr_d    = bit_tmr;
    bit_idx_d    = bit_idx;
    byte_idx_d   = byte_idx;
    tx_d         = tx;
    frame_done_d = 1'b0;
    cap_en       = 1'b0;
    overflow_d   = enable && ((state == WAIT_CRC) || (state == SEND));

    case (state)
      IDLE, COLLECT: begin
        if (enable) begin
          cap_en = 1'b1;
          if (cnt == CNT_W'(PAYLOAD_LEN - 1)) begin
            cnt_d   = '0;
            state_d = WAIT_CRC;
          end else begin
            cnt_d   = cnt + CNT_W'(1);
            state_d = COLLECT;
          end
        end
      end

      WAIT_CRC: begin
        if (crc_done) begin
          crc_q_d    = crc;
          state_d    = SEND;
          tx_d       = 1'b0;
          bit_tmr_d  = '0;
          bit_idx_d  = '0;
          byte_idx_d = '0;
        end
      end

      SEND: begin
        if (bit_tmr == TMR_W'(CLKS_PER_BIT - 1)) begin
          bit_tmr_d = '0;
          if (bit_idx == BIT_W'(STOP_BIT)) begin
            bit_idx_d = '0;
            if (byte_idx == BYTE_W'(LAST_BYTE)) begin
              byte_idx_d   = '0;
              state_d      = IDLE;
              tx_d         = 1'b1;
              frame_done_d = 1'b1;
            end else begin
              byte_idx_d = byte_idx + BYTE_W'(1);
              tx_d       = 1'b0;
            end
          end else begin
            // Ending bit k moves to bit k+1: data bit k for k<8, stop after.
            bit_idx_d = bit_idx + BIT_W'(1);
            tx_d      = (bit_idx == BIT_W'(LAST_DATA)) ? 1'b1 : cur_byte[bit_idx[2:0]];
          end
        end else begin
          bit_tmr_d = bit_tmr + TMR_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == WAIT_CRC) || (state_d == SEND);
  end

  // State, counters and outputs; reset abandons any partial frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      crc_q      <= '0;
      bit_tmr    <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      crc_q      <= crc_q_d;
      bit_tmr    <= bit_tmr_d;
      bit_idx    <= bit_idx_d;
      byte_idx   <= byte_idx_d;
      tx         <= tx_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      overflow   <= overflow_d;
    end
  end

  // Payload storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (cap_en) begin
      pay_buf[cnt] <= data_in;
    end
  end

endmodule

// File: tb/tb_crc_frame_tx.sv
// Bench for crc_frame_tx: bit-stream model compared every cycle, plus decoded
// frames and pulse counts checked against hand-written byte lists.
module tb_crc_frame_tx;

  localparam int N = 8;
  localparam int C = 4;
  localparam int L = 10 * (N + 2) * C;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       crc_done = 1'b0;
  logic [7:0] crc = 8'h00;
  logic       tx, busy, frame_done, overflow;

  int vectors = 0;
  int errors  = 0;
  int ovf_cnt = 0;
  int fd_cnt  = 0;

  logic [7:0] pay [N];

  crc_frame_tx #(
    .PAYLOAD_LEN (N),
    .CLKS_PER_BIT(C),
    .SOF         (8'h7E)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .data_in   (data_in),
    .crc_done  (crc_done),
    .crc       (crc),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: payload queue, then a queue of expected tx samples.
  logic [7:0] m_pay [$];
  logic       m_txq [$];
  bit         m_wait = 1'b0;
  bit         m_send = 1'b0;
  logic       m_tx = 1'b1;
  logic       m_busy = 1'b0;
  logic       m_fd = 1'b0;
  logic       m_ovf = 1'b0;
  int         m_len = 0;

  function automatic void build_frame(input logic [7:0] crcv);
    logic [7:0] bytes [$];
    logic [9:0] bits;
    bytes.push_back(8'h7E);
    foreach (m_pay[i]) bytes.push_back(m_pay[i]);
    bytes.push_back(crcv);
    m_txq.delete();
    foreach (bytes[k]) begin
      bits = {1'b1, bytes[k], 1'b0};
      for (int b = 0; b < 10; b++)
        for (int t = 0; t < C; t++) m_txq.push_back(bits[b]);
    end
    m_len = m_txq.size();
    m_pay.delete();
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pay.delete();
      m_txq.delete();
      m_wait = 1'b0;
      m_send = 1'b0;
      m_tx   = 1'b1;
      m_busy = 1'b0;
      m_fd   = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      m_fd  = 1'b0;
      m_ovf = (m_wait || m_send) && enable;
      if (m_send) begin
        if (m_txq.size() > 0) begin
          m_tx = m_txq.pop_front();
        end else begin
          m_send = 1'b0;
          m_fd   = 1'b1;
          m_tx   = 1'b1;
        end
      end else if (m_wait) begin
        if (crc_done) begin
          build_frame(crc);
          m_wait = 1'b0;
          m_send = 1'b1;
          m_tx   = m_txq.pop_front();
        end
      end else if (enable) begin
        m_pay.push_back(data_in);
        if (m_pay.size() == N) m_wait = 1'b1;
      end
      m_busy = m_wait || m_send;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    check("tx", 32'(tx), 32'(m_tx));
    check("busy", 32'(busy), 32'(m_busy));
    check("frame_done", 32'(frame_done), 32'(m_fd));
    check("overflow", 32'(overflow), 32'(m_ovf));
  end

  // Pulse counters.
  always @(negedge clk) begin
    if (overflow) ovf_cnt++;
    if (frame_done) fd_cnt++;
  end

  task automatic offer(input logic [7:0] d);
    enable  = 1'b1;
    data_in = d;
    @(negedge clk);
    enable  = 1'b0;
  endtask

  task automatic load_payload(input int gap, input int extra);
    for (int i = 0; i < N; i++) begin
      offer(pay[i]);
      if (i < N - 1) repeat (gap) @(negedge clk);
    end
    for (int i = 0; i < extra; i++) offer(8'hFF);
  endtask

  // Raise crc_done, record the whole frame, decode it and check its end.
  task automatic run_send(input logic [7:0] crcv);
    logic       samp [L];
    logic [7:0] expf [N + 2];
    logic [7:0] got;
    int         fd_seen;
    fd_seen = 0;
    expf[0] = 8'h7E;
    for (int i = 0; i < N; i++) expf[i + 1] = pay[i];
    expf[N + 1] = crcv;
    crc      = crcv;
    crc_done = 1'b1;
    @(negedge clk);
    crc_done = 1'b0;
    for (int i = 0; i < L; i++) begin
      samp[i] = tx;
      if (frame_done) fd_seen++;
      @(negedge clk);
    end
    check("fd_before_end", 32'(fd_seen), 32'd0);
    check("fd_at_frame_end", 32'(frame_done), 32'd1);
    check("busy_at_frame_end", 32'(busy), 32'd0);
    check("tx_at_frame_end", 32'(tx), 32'd1);
    for (int k = 0; k < N + 2; k++) begin
      check("start_bit", 32'(samp[(k * 10) * C + C / 2]), 32'd0);
      for (int b = 0; b < 8; b++) got[b] = samp[(k * 10 + 1 + b) * C + C / 2];
      check("frame_byte", 32'(got), 32'(expf[k]));
      check("stop_bit", 32'(samp[(k * 10 + 9) * C + C / 2]), 32'd1);
    end
    @(negedge clk);
    check("fd_one_cycle", 32'(frame_done), 32'd0);
  endtask

  initial begin
    int ov0, fd0;
    pay = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h31, 8'h32, 8'h33};

    // Reset held with random inputs.
    repeat (4) begin
      @(negedge clk);
      enable   = 1'($urandom);
      data_in  = 8'($urandom);
      crc_done = 1'($urandom);
      crc      = 8'($urandom);
    end
    @(negedge clk);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    enable   = 1'b0;
    crc_done = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal frame.
    ov0 = ovf_cnt; fd0 = fd_cnt;
    load_payload(0, 0);
    check("busy_wait_crc", 32'(busy), 32'd1);
    run_send(8'hA5);
    check("model_frame_len", 32'(m_len), 32'd400);
    repeat (2) @(negedge clk);
    check("nominal_fd_count", 32'(fd_cnt - fd0), 32'd1);
    check("nominal_ovf_count", 32'(ovf_cnt - ov0), 32'd0);

    // Gapped enable.
    ov0 = ovf_cnt; fd0 = fd_cnt;
    load_payload(3, 0);
    run_send(8'hA5);
    repeat (2) @(negedge clk);
    check("gapped_fd_count", 32'(fd_cnt - fd0), 32'd1);
    check("gapped_ovf_count", 32'(ovf_cnt - ov0), 32'd0);

    // Excess bytes while waiting for the CRC.
    ov0 = ovf_cnt;
    load_payload(0, 2);
    run_send(8'hA5);
    repeat (2) @(negedge clk);
    check("excess_ovf_count", 32'(ovf_cnt - ov0), 32'd2);

    // Early crc_done during collection is ignored.
    for (int i = 0; i < 4; i++) offer(pay[i]);
    crc      = 8'h11;
    crc_done = 1'b1;
    for (int i = 4; i < N; i++) offer(pay[i]);
    crc_done = 1'b0;
    repeat (5) @(negedge clk);
    check("early_crc_still_waiting", 32'(busy), 32'd1);
    check("early_crc_tx_idle", 32'(tx), 32'd1);
    run_send(8'hA5);
    repeat (2) @(negedge clk);

    // Reset in the middle of payload byte 4 (data bit 4 of 6F is 0).
    load_payload(0, 0);
    crc      = 8'hA5;
    crc_done = 1'b1;
    @(negedge clk);
    crc_done = 1'b0;
    repeat (221) @(negedge clk);
    check("tx_pre_reset", 32'(tx), 32'd0);
    fd0 = fd_cnt;
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_tx", 32'(tx), 32'd1);
    check("async_reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("no_fd_after_reset", 32'(fd_cnt - fd0), 32'd0);
    load_payload(0, 0);
    run_send(8'hA5);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/crc_frame_tx.md
# crc_frame_tx

Downstream stage of the CRC generator in the serial security wrapper. It captures the payload bytes presented to the CRC block and waits for that block's `crc_done`/`crc` result. It then transmits one framed packet on a UART 8N1 line: SOF byte, the payload bytes in arrival order, then the CRC byte. It shares `enable`/`data_in` with the CRC block, so both see the same byte stream.

## Interface
- `PAYLOAD_LEN`, default 8: payload bytes per frame; legal range is ≥1.
- `CLKS_PER_BIT`, default 4: clock cycles per UART bit; legal range is ≥2.
- `SOF`, default 8'h7E: start-of-frame byte sent first.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `enable` input 1: byte strobe. When high, one byte is offered on `data_in` each cycle.
- `data_in` input 8: payload byte.
- `crc_done` input 1: level flag from the CRC block meaning `crc` is valid.
- `crc` input 8: CRC result byte.
- `tx` output 1: UART serial out; idles high.
- `busy` output 1: high in WAIT_CRC and SEND.
- `frame_done` output 1: one-cycle pulse when the frame's last stop bit completes.
- `overflow` output 1: one-cycle pulse for each byte offered while the block cannot accept it.

## Operation
- The FSM has four states: IDLE, COLLECT, WAIT_CRC and SEND.
- **IDLE / COLLECT:**
  - Each cycle with `enable`=1 writes `data_in` into `buf[cnt]` and increments `cnt`.
  - The first capture moves the FSM from IDLE to COLLECT.
  - `enable`=0 holds state. There is no timeout.
- **Collection complete:** the capture that writes `buf[PAYLOAD_LEN-1]` moves the FSM to WAIT_CRC on the same edge and clears `cnt`.
- **Bytes offered while busy:** `enable`=1 in WAIT_CRC or SEND drops the byte and sets `overflow` high for the following cycle. The buffer is unchanged.
- **WAIT_CRC:**
  - `crc_done` is sampled every cycle, including the first cycle after the last capture.
  - On `crc_done`=1, `crc` is latched and the FSM moves to SEND.
  - `crc_done` in IDLE or COLLECT is ignored. It is not remembered.
- **SEND:**
  - Byte sequence: `SOF`, `buf[0]` … `buf[PAYLOAD_LEN-1]`, latched CRC.
  - Each byte is sent as: start bit 0, data bits LSB first, stop bit 1. Every bit lasts `CLKS_PER_BIT` cycles.
  - Counters: a bit-timer 0..`CLKS_PER_BIT`-1, a bit index 0..9, and a byte index 0..`PAYLOAD_LEN`+1. Widths are $clog2-sized.
  - After the last stop bit of the CRC byte, the FSM returns to IDLE and `frame_done` pulses.
- **Output registering:** `tx` comes from a register, not from combinational decode.
- **Reset** (asynchronous, any state, including mid-frame) forces:
  - state IDLE, `cnt`=0, all counters 0;
  - `tx`=1, `busy`=0, `frame_done`=0, `overflow`=0.
  - The buffer contents are don't-care.
  - Any partial frame is abandoned. It is not resumed.

## Timing
- **Start of transmission:** if `crc_done` is sampled high at edge E, `tx`=0 (start bit of SOF) from E onward.
- **Frame length:** 10·(`PAYLOAD_LEN`+2)·`CLKS_PER_BIT` cycles. With defaults this is 400 cycles.
- **End of frame:** at the edge ending the final stop bit, state becomes IDLE, `busy` falls, `frame_done`=1 for exactly one cycle, and `tx` stays 1.
- **Earliest next capture:** `enable` in the `frame_done` cycle is captured as byte 0 of the next frame.
- **Minimum first-byte-to-SEND latency:** `PAYLOAD_LEN` cycles of continuous `enable`, plus 1 cycle if `crc_done` is already high.
- **Overflow:** `overflow` is registered; it is high in the cycle after the rejected offer.
- **Busy window:** `busy`=1 from the edge entering WAIT_CRC through the last stop-bit cycle.

## Test plan
1. **Reset.** Hold `reset_n`=0 with random inputs → `tx`=1, `busy`=0, `frame_done`=0, `overflow`=0. Assert reset asynchronously between edges → outputs change immediately.
2. **Nominal frame.**
   - Stimulus: bytes 48 65 6C 6C 6F 31 32 33 on 8 consecutive enabled cycles, then `crc_done`=1 with `crc`=8'hA5.
   - Required: `tx` decodes 7E 48 65 6C 6C 6F 31 32 33 A5 (8N1, 4 clocks/bit); `frame_done` pulses once, 400 cycles after the start bit; `busy` falls on the same edge.
3. **Gapped enable.** Same bytes with `enable`=0 for 3 cycles between each byte → identical `tx` frame; no overflow.
4. **Excess bytes.** Keep `enable`=1 for 2 cycles after the 8th byte with `data_in`=FF → 2 `overflow` pulses; the transmitted frame is unchanged from scenario 2.
5. **Early `crc_done`.**
   - Stimulus: `crc_done`=1, `crc`=11 during COLLECT; then `crc_done`=0; then `crc_done`=1, `crc`=A5 in WAIT_CRC.
   - Required: the last frame byte is A5; the FSM stays in WAIT_CRC until the second assertion.
6. **Reset mid-SEND.** Pulse `reset_n` low during payload byte 4 → `tx`=1 and `busy`=0 immediately, no `frame_done`. A following full sequence produces a correct frame.
